// File: rtl/dot_product_sequencer.sv
// Sequences one dot-product job through the downstream fixed-point FMA unit.
// Optional abort support is compiled in when SEQ_ABORT_EN is defined.
module dot_product_sequencer #(
    parameter int WIDTH     = 16,
    parameter int LEN_WIDTH = 8
) (
    input  logic                 clk_in,
    input  logic                 rst_n_in,
    input  logic                 start_in,
    input  logic [LEN_WIDTH-1:0] length_in,
    input  logic [WIDTH-1:0]     bias_in,
    input  logic [WIDTH-1:0]     a_data_in,
    input  logic [WIDTH-1:0]     b_data_in,
    input  logic                 pair_valid_in,
    output logic                 pair_ready_out,
    output logic [WIDTH-1:0]     fma_a_out,
    output logic [WIDTH-1:0]     fma_b_out,
    output logic [WIDTH-1:0]     fma_c_out,
    output logic                 fma_a_valid_out,
    output logic                 fma_b_valid_out,
    output logic                 fma_c_valid_out,
    output logic                 fma_compute_out,
    input  logic [WIDTH-1:0]     fma_result_in,
    output logic [WIDTH-1:0]     result_out,
    output logic                 result_valid_out,
    output logic                 busy_out
`ifdef SEQ_ABORT_EN
    ,
    input  logic                 abort_in,
    output logic                 aborted_out
`endif
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_RUN    = 2'd1;
    localparam logic [1:0] ST_FINISH = 2'd2;

    logic [1:0]           state_q, state_d;
    logic [LEN_WIDTH-1:0] remaining_q, remaining_d;
    logic [WIDTH-1:0]     bias_q, bias_d;
    logic                 first_q, first_d;
    logic                 zero_len_q, zero_len_d;
    logic [WIDTH-1:0]     result_q, result_d;
    logic                 result_valid_q, result_valid_d;
    logic                 abort_req;
    logic                 fire;

`ifdef SEQ_ABORT_EN
    logic aborted_q, aborted_d;

    assign abort_req = abort_in;

    always_comb begin
        aborted_d = (state_q == ST_RUN) && abort_in;
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            aborted_q <= 1'b0;
        end else begin
            aborted_q <= aborted_d;
        end
    end

    assign aborted_out = aborted_q;
`else
    assign abort_req = 1'b0;
`endif

    always_comb begin
        state_d         = state_q;
        remaining_d     = remaining_q;
        bias_d          = bias_q;
        first_d         = first_q;
        zero_len_d      = zero_len_q;
        result_d        = result_q;
        result_valid_d  = 1'b0;
        pair_ready_out  = 1'b0;
        fire            = 1'b0;
        fma_a_out       = '0;
        fma_b_out       = '0;
        fma_c_out       = '0;
        fma_a_valid_out = 1'b0;
        fma_b_valid_out = 1'b0;
        fma_c_valid_out = 1'b0;
        fma_compute_out = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start_in) begin
                    bias_d = bias_in;
                    if (length_in != '0) begin
                        remaining_d = length_in;
                        first_d     = 1'b1;
                        zero_len_d  = 1'b0;
                        state_d     = ST_RUN;
                    end else begin
                        zero_len_d  = 1'b1;
                        state_d     = ST_FINISH;
                    end
                end
            end

            ST_RUN: begin
                fma_a_out = a_data_in;
                fma_b_out = b_data_in;
                fma_c_out = bias_q;
                if (abort_req) begin
                    // Abort wins over a pair offered in the same cycle.
                    state_d = ST_IDLE;
                end else begin
                    pair_ready_out  = 1'b1;
                    fire            = pair_valid_in;
                    fma_a_valid_out = fire;
                    fma_b_valid_out = fire;
                    fma_compute_out = fire;
                    fma_c_valid_out = fire && first_q;
                    if (fire) begin
                        first_d     = 1'b0;
                        remaining_d = remaining_q - LEN_WIDTH'(1);
                        if (remaining_q == LEN_WIDTH'(1)) begin
                            state_d = ST_FINISH;
                        end
                    end
                end
            end

            ST_FINISH: begin
                // The FMA registered the final sum on the last fire edge.
                result_d       = zero_len_q ? bias_q : fma_result_in;
                result_valid_d = 1'b1;
                zero_len_d     = 1'b0;
                state_d        = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q        <= ST_IDLE;
            remaining_q    <= '0;
            bias_q         <= '0;
            first_q        <= 1'b0;
            zero_len_q     <= 1'b0;
            result_q       <= '0;
            result_valid_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            remaining_q    <= remaining_d;
            bias_q         <= bias_d;
            first_q        <= first_d;
            zero_len_q     <= zero_len_d;
            result_q       <= result_d;
            result_valid_q <= result_valid_d;
        end
    end

    assign result_out       = result_q;
    assign result_valid_out = result_valid_q;
    assign busy_out         = (state_q != ST_IDLE);

endmodule

// File: tb/tb_dot_product_sequencer.sv
// Bench for dot_product_sequencer: a behavioural FMA closes the loop, and a
// scoreboard queue holds the hand-computed result and cycle for each job.
module tb_dot_product_sequencer;
    localparam int W  = 16;
    localparam int LW = 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic [LW-1:0] length;
    logic [W-1:0]  bias;
    logic [W-1:0]  a_data, b_data;
    logic          pair_valid;
    logic          pair_ready;
    logic [W-1:0]  fma_a, fma_b, fma_c;
    logic          fma_a_valid, fma_b_valid, fma_c_valid, fma_compute;
    logic [W-1:0]  fma_result;
    logic [W-1:0]  result;
    logic          result_valid;
    logic          busy;
`ifdef SEQ_ABORT_EN
    logic          abort;
    logic          aborted;
`endif

    always #5 clk = ~clk;

    dot_product_sequencer #(.WIDTH(W), .LEN_WIDTH(LW)) dut (
        .clk_in          (clk),
        .rst_n_in        (rst_n),
        .start_in        (start),
        .length_in       (length),
        .bias_in         (bias),
        .a_data_in       (a_data),
        .b_data_in       (b_data),
        .pair_valid_in   (pair_valid),
        .pair_ready_out  (pair_ready),
        .fma_a_out       (fma_a),
        .fma_b_out       (fma_b),
        .fma_c_out       (fma_c),
        .fma_a_valid_out (fma_a_valid),
        .fma_b_valid_out (fma_b_valid),
        .fma_c_valid_out (fma_c_valid),
        .fma_compute_out (fma_compute),
        .fma_result_in   (fma_result),
        .result_out      (result),
        .result_valid_out(result_valid),
        .busy_out        (busy)
`ifdef SEQ_ABORT_EN
        ,
        .abort_in        (abort),
        .aborted_out     (aborted)
`endif
    );

    // Behavioural Q6.10 FMA: acc <= (a*b >>> 10) + (c_valid ? c : acc)
    logic [W-1:0] acc;
    function automatic logic [W-1:0] mulfp(input logic [W-1:0] x, input logic [W-1:0] y);
        logic signed [2*W-1:0] p;
        p = $signed(x) * $signed(y);
        p = p >>> 10;
        return p[W-1:0];
    endfunction
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) acc <= '0;
        else if (fma_compute) acc <= mulfp(fma_a, fma_b) + (fma_c_valid ? fma_c : acc);
    end
    assign fma_result = acc;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [W-1:0] val;
        int           cyc;
    } exp_t;
    exp_t sb[$];

    int n_tests = 0;
    int n_fail  = 0;
    int compute_cnt = 0;
    int cvalid_cnt  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end else begin
            $display("[TB] ok %s = %0h", name, act);
        end
    endtask

    // Monitor: pops the scoreboard whenever the DUT presents a result.
    always @(negedge clk) begin
        if (rst_n) begin
            if (fma_compute) compute_cnt++;
            if (fma_c_valid) cvalid_cnt++;
            if (result_valid) begin
                if (sb.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_result: got %0h expected none (cycle %0d)", result, cyc);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("result_value", 32'(result), 32'(e.val));
                    check("result_cycle", 32'(cyc), 32'(e.cyc));
                end
            end
        end
    end

    task automatic start_job(input logic [LW-1:0] len, input logic [W-1:0] b);
        start  = 1'b1;
        length = len;
        bias   = b;
        if (len == '0) sb.push_back('{b, cyc + 2});
        @(posedge clk); #1;
        start = 1'b0;
        check("busy_after_start", 32'(busy), 32'd1);
    endtask

    task automatic send_pair(input logic [W-1:0] a, input logic [W-1:0] b, input int gap,
                             input logic last, input logic [W-1:0] exp_val);
        pair_valid = 1'b0;
        repeat (gap) begin @(posedge clk); #1; end
        a_data     = a;
        b_data     = b;
        pair_valid = 1'b1;
        for (int i = 0; i < 20 && !pair_ready; i++) begin @(posedge clk); #1; end
        if (!pair_ready) begin
            check("pair_accept_timeout", 32'(pair_ready), 32'd1);
            pair_valid = 1'b0;
            return;
        end
        if (last) sb.push_back('{exp_val, cyc + 2});
        @(posedge clk); #1;
        pair_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int i;
        for (i = 0; i < 30 && (sb.size() != 0 || busy); i++) begin @(posedge clk); #1; end
        if (i == 30) check("job_completion_timeout", 32'(sb.size()), 32'd0);
    endtask

    task automatic run_job1(input int gap);
        int c0, v0;
        c0 = compute_cnt;
        v0 = cvalid_cnt;
        start_job(8'd3, 16'h0100);
        check("fma_c_is_bias", 32'(fma_c), 32'h0100);
        check("no_compute_without_pair", 32'(fma_compute), 32'd0);
        send_pair(16'h0400, 16'h0800, 0,   1'b0, 16'h0);
        send_pair(16'h0800, 16'h0600, gap, 1'b0, 16'h0);
        send_pair(16'h0200, 16'h1000, gap, 1'b1, 16'h1D00);
        wait_idle();
        check("compute_pulses", 32'(compute_cnt - c0), 32'd3);
        check("c_valid_pulses", 32'(cvalid_cnt - v0), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int c0;
        rst_n = 1'b0; start = 1'b0; length = '0; bias = '0;
        a_data = '0; b_data = '0; pair_valid = 1'b0;
`ifdef SEQ_ABORT_EN
        abort = 1'b0;
`endif
        repeat (3) @(posedge clk);
        #1;
        check("reset_result", 32'(result), 32'd0);
        check("reset_result_valid", 32'(result_valid), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_ready", 32'(pair_ready), 32'd0);
        check("reset_compute", 32'(fma_compute), 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        pair_valid = 1'b1;
        #1;
        check("idle_ready_low", 32'(pair_ready), 32'd0);
        pair_valid = 1'b0;

        // Back-to-back beats, then the same job with 2-cycle bubbles.
        run_job1(0);
        run_job1(2);

        // Zero-length job.
        c0 = compute_cnt;
        start_job(8'd0, 16'h0C00);
        check("finish_ready_low", 32'(pair_ready), 32'd0);
        wait_idle();
        check("zero_len_no_compute", 32'(compute_cnt - c0), 32'd0);

        // Start mid-RUN ignored; second start accepted in the result_valid cycle.
        start_job(8'd3, 16'h0100);
        send_pair(16'h0400, 16'h0800, 0, 1'b0, 16'h0);
        start = 1'b1; length = 8'd5; bias = 16'h7777;
        @(posedge clk); #1;
        start = 1'b0;
        send_pair(16'h0800, 16'h0600, 0, 1'b0, 16'h0);
        send_pair(16'h0200, 16'h1000, 0, 1'b1, 16'h1D00);
        @(posedge clk); #1;
        check("result_valid_at_restart", 32'(result_valid), 32'd1);
        start_job(8'd2, 16'h0000);
        send_pair(16'h0C00, 16'h0400, 0, 1'b0, 16'h0);
        send_pair(16'hFC00, 16'h0800, 0, 1'b1, 16'h0400);
        wait_idle();

        // Asynchronous reset after 1 of 3 beats.
        start_job(8'd3, 16'h0100);
        send_pair(16'h0400, 16'h0800, 0, 1'b0, 16'h0);
        pair_valid = 1'b1;
        #1;
        rst_n = 1'b0;
        #1;
        check("midreset_busy", 32'(busy), 32'd0);
        check("midreset_ready", 32'(pair_ready), 32'd0);
        check("midreset_compute", 32'(fma_compute), 32'd0);
        check("midreset_result_valid", 32'(result_valid), 32'd0);
        pair_valid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        run_job1(0);

`ifdef SEQ_ABORT_EN
        start_job(8'd4, 16'h0000);
        send_pair(16'h0400, 16'h0400, 0, 1'b0, 16'h0);
        pair_valid = 1'b1;
        abort = 1'b1;
        #1;
        check("abort_ready_low", 32'(pair_ready), 32'd0);
        check("abort_no_compute", 32'(fma_compute), 32'd0);
        @(posedge clk); #1;
        abort = 1'b0;
        pair_valid = 1'b0;
        check("aborted_pulse", 32'(aborted), 32'd1);
        check("abort_busy_low", 32'(busy), 32'd0);
        @(posedge clk); #1;
        check("aborted_one_cycle", 32'(aborted), 32'd0);
        repeat (3) @(posedge clk);
        #1;
`endif

        check("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/dot_product_sequencer.md
Name: dot_product_sequencer

Overview:
- Control stage directly upstream of the fixed-point FMA unit. Drives one complete dot product through it.
- Accepts a job (length, bias), then consumes a valid/ready stream of (a, b) operand pairs. Drives the FMA's operand, valid and compute inputs cycle by cycle.
- After the last pair, captures the FMA accumulator output as the job result and pulses result_valid.

Parameters:
- WIDTH, 16, bits per fixed-point operand/result; must match the FMA.
- LEN_WIDTH, 8, width of the job length field (max 2^LEN_WIDTH-1 pairs).

Ports:
- clk_in  input  1  system clock
- rst_n_in  input  1  reset, asynchronous, active-low
- start_in  input  1  job request; sampled only in IDLE
- length_in  input  LEN_WIDTH  number of pairs in the job
- bias_in  input  WIDTH  initial accumulator addend
- a_data_in  input  WIDTH  operand a of current pair
- b_data_in  input  WIDTH  operand b of current pair
- pair_valid_in  input  1  pair present
- pair_ready_out  output  1  sequencer can take a pair
- fma_a_out  output  WIDTH  to FMA a
- fma_b_out  output  WIDTH  to FMA b
- fma_c_out  output  WIDTH  to FMA c
- fma_a_valid_out  output  1  to FMA a_valid_in
- fma_b_valid_out  output  1  to FMA b_valid_in
- fma_c_valid_out  output  1  to FMA c_valid_in
- fma_compute_out  output  1  to FMA compute
- fma_result_in  input  WIDTH  from FMA out
- result_out  output  WIDTH  captured dot product
- result_valid_out  output  1  one-cycle pulse, result_out valid
- busy_out  output  1  high in any state but IDLE

Behaviour:
- Reset: clk_in single clock; rst_n_in asynchronous active-low. While low: state=IDLE, result_out=0, result_valid_out=0, counters/bias register=0. All combinational FMA drives are 0 in IDLE.
- States: IDLE, RUN, FINISH.
- IDLE:
  - start_in=1 and length_in>0: latch length into remaining and bias_in into bias_reg, set first=1, go to RUN.
  - start_in=1 and length_in=0: go to FINISH with zero-length flag set.
- RUN:
  - pair_ready_out=1. fire = pair_valid_in & pair_ready_out.
  - fma_a_out=a_data_in, fma_b_out=b_data_in, fma_c_out=bias_reg (all combinational).
  - fma_a_valid_out = fma_b_valid_out = fma_compute_out = fire.
  - fma_c_valid_out = fire & first.
  - On fire: first<=0, remaining<=remaining-1. If remaining==1, go to FINISH.
  - No fire (bubble): no compute; the FMA accumulator holds.
- FINISH (exactly one cycle): fma_result_in already holds the final sum, since the FMA registered it on the last fire edge.
  - Normal job: result_out<=fma_result_in.
  - Zero-length job: result_out<=bias_reg.
  - result_valid_out<=1 for one cycle; go to IDLE.
- Latency: last fire in cycle k gives result_valid_out high in cycle k+2.
- Arithmetic is done entirely in the FMA (product >> FIXED_POINT, plus c, wrap on overflow). The sequencer passes values through unmodified.
- start_in while busy is ignored, with no queuing.
- Back-to-back jobs: start_in accepted in the cycle result_valid_out is high (state is IDLE). The stale FMA accumulator is overwritten by the first beat via fma_c_valid_out.
- pair_ready_out=0 in IDLE and FINISH; pairs offered there are not consumed.
- Async reset mid-job: immediate return to IDLE, no result_valid_out. The FMA reset is driven separately.

Optional Feature:
- Macro SEQ_ABORT_EN.
- Defined: adds input abort_in (1 bit) and output aborted_out (1 bit).
  - abort_in=1 in RUN: go to IDLE next edge, suppress fire that cycle (ready forced 0), no result_valid_out, aborted_out pulses one cycle.
  - abort_in is ignored in IDLE and FINISH.
- Undefined: neither port exists; a job always runs to completion.

Test Plan:
- WIDTH=16, FIXED_POINT=10. length=3, bias=0x0100 (0.25); pairs (0x0400,0x0800), (0x0800,0x0600), (0x0200,0x1000) back-to-back -> compute high 3 cycles, c_valid only on first; result_out=0x1D00 (7.25) with result_valid pulse 2 cycles after the last fire.
- Same job with pair_valid_in low for 2 cycles between beats -> no compute in gaps; result_out still 0x1D00, latency measured from the last fire.
- length=0, bias=0x0C00 -> no fma_compute_out ever; result_out=0x0C00, result_valid 2 cycles after start.
- start_in pulsed mid-RUN with length=5 -> ignored; the first job completes with its own length. A second start in the result_valid cycle is accepted and gives a correct independent sum.
- rst_n_in pulled low after 1 of 3 beats -> outputs 0 immediately, busy_out=0. A fresh job then returns the correct result.
- SEQ_ABORT_EN defined: abort_in during beat 2 of 4 -> aborted_out one-cycle pulse, no result_valid_out, pair_ready_out=0 that cycle.
